// File: rtl/wb_mux_n.sv
// wb_mux_n: N-way Wishbone classic interconnect from the CPU data bus to
// NUM_SLAVES peripherals. The slave index comes from the top ADR_SEL_W address
// bits. Slaves return their own ack, and read data is registered. The block
// completes the cycle itself, with err set, on a decode miss.
// Optional build macro WB_MUX_TIMEOUT_EN: when it is defined, a transfer that
// waits TIMEOUT_CYCLES cycles for a slave ack is forced to complete with err.
module wb_mux_n #(
   parameter int unsigned NUM_SLAVES     = 4,
   parameter int unsigned ADR_SEL_W      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [31:0]               i_wb_cpu_adr,
   input  logic [31:0]               i_wb_cpu_dat,
   input  logic [3:0]                i_wb_cpu_sel,
   input  logic                      i_wb_cpu_we,
   input  logic                      i_wb_cpu_cyc,
   output logic [31:0]               o_wb_cpu_rdt,
   output logic                      o_wb_cpu_ack,
   output logic                      o_wb_cpu_err,
   output logic [31:0]               o_wb_s_adr,
   output logic [31:0]               o_wb_s_dat,
   output logic [3:0]                o_wb_s_sel,
   output logic                      o_wb_s_we,
   output logic [NUM_SLAVES-1:0]     o_wb_s_cyc,
   input  logic [32*NUM_SLAVES-1:0]  i_wb_s_rdt,
   input  logic [NUM_SLAVES-1:0]     i_wb_s_ack
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADR_SEL_W-1:0]   idx_q, idx_d;
   logic                   ack_q, ack_d;
   logic                   err_q, err_d;
   logic [31:0]            rdt_q, rdt_d;

   logic [ADR_SEL_W-1:0]   adr_idx;
   logic                   adr_hit;
   logic                   sel_ack;
   logic [31:0]            sel_rdt;
   logic                   timeout;

   // Reject parameter values that the decode and timeout logic cannot support
   if (NUM_SLAVES < 1 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("wb_mux_n: parameter out of range");
   end

   // Broadcast the request fields unchanged to every slave
   assign o_wb_s_adr = i_wb_cpu_adr;
   assign o_wb_s_dat = i_wb_cpu_dat;
   assign o_wb_s_sel = i_wb_cpu_sel;
   assign o_wb_s_we  = i_wb_cpu_we;

   // Decode the slave index and check that it names an attached slave
   assign adr_idx = i_wb_cpu_adr[31 -: ADR_SEL_W];
   assign adr_hit = 32'(adr_idx) < NUM_SLAVES;

   // Pick the ack and read data of the latched slave; other slaves' acks are ignored
   always_comb begin
      sel_ack = 1'b0;
      sel_rdt = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (idx_q == ADR_SEL_W'(i)) begin
            sel_ack = i_wb_s_ack[i];
            sel_rdt = i_wb_s_rdt[32*i +: 32];
         end
      end
   end

   // One-hot slave cyc; it drops at once when the CPU drops cyc
   always_comb begin
      o_wb_s_cyc = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         o_wb_s_cyc[i] = (state_q == S_ACTIVE) && i_wb_cpu_cyc && (idx_q == ADR_SEL_W'(i));
      end
   end

`ifdef WB_MUX_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count the cycles spent in ACTIVE; the count returns to zero in any other state
   always_comb begin
      cnt_d = '0;
      if (state_q == S_ACTIVE) cnt_d = cnt_q + CNT_W'(1);
   end

   // Timeout counter register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and response logic; ack and err are high only in RESP
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdt_d   = rdt_q;
      case (state_q)
         S_IDLE: begin
            if (i_wb_cpu_cyc) begin
               idx_d = adr_idx;
               if (adr_hit) begin
                  state_d = S_ACTIVE;
               end else begin
                  state_d = S_RESP;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  rdt_d   = '0;
               end
            end
         end
         S_ACTIVE: begin
            if (!i_wb_cpu_cyc) begin
               state_d = S_IDLE;
            end else if (sel_ack) begin
               state_d = S_RESP;
               ack_d   = 1'b1;
               rdt_d   = sel_rdt;
            end else if (timeout) begin
               state_d = S_RESP;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               rdt_d   = '0;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and response registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdt_q   <= rdt_d;
      end
   end

   assign o_wb_cpu_ack = ack_q;
   assign o_wb_cpu_err = err_q;
   assign o_wb_cpu_rdt = rdt_q;

endmodule
